crc3_frame_arbiter: RTL

Round-robin scheduler that shares one serial CRC-3 encoding engine between `NUM_REQ` requesters. Each requester presents a 5-bit message. The block grants one requester at a time and sequences the engine through 5 data bits and 3 flush bits. It then returns the 8-bit codeword `{msg, crc}` over a valid/ready output handshake. It sits between message producers and the downstream codeword consumer.

---
 rtl/crc3_pkg.sv | 25 ++
 rtl/crc3_shift_engine.sv | 64 ++++++
 rtl/crc3_frame_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/crc3_pkg.sv
// crc3_pkg: shared constants, the FSM state type and the one-step CRC-3
// update used by the frame arbiter and its shift engine.
//   MSG_W     - message width in bits
//   CRC_W     - CRC width in bits
//   FRAME_LEN - serial steps per frame (data bits plus flush bits)
package crc3_pkg;

  localparam int MSG_W     = 5;
  localparam int CRC_W     = 3;
  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One serial step of the x^3+x+1 register; new bit enters at the top.
  function automatic logic [CRC_W-1:0] crc3_step(input logic [CRC_W-1:0] crc,
                                                 input logic             b);
    return {b ^ crc[2] ^ crc[0], crc[2:1]};
  endfunction

endpackage

// File: rtl/crc3_shift_engine.sv
// crc3_shift_engine: message register, CRC register and bit counter for one
// serial CRC-3 encoding pass.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   load        - capture msg_in, clear crc and counter
//   step        - advance one serial step
//   msg_in      - message to capture on load
//   msg         - captured message
//   crc_next    - CRC value after the current step
//   last        - current step is the final one of the frame
module crc3_shift_engine
  import crc3_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [MSG_W-1:0] msg_in,
  output logic [MSG_W-1:0] msg,
  output logic [CRC_W-1:0] crc_next,
  output logic             last
);

  logic [MSG_W-1:0] msg_q, msg_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] bit_idx;
  logic             bit_in;

  always_comb begin
    // MSB-first data bits, then zero flush bits.
    bit_idx  = CNT_W'(MSG_W - 1) - cnt_q;
    bit_in   = (cnt_q < CNT_W'(MSG_W)) ? msg_q[bit_idx] : 1'b0;
    crc_next = crc3_step(crc_q, bit_in);

    msg_d = msg_q;
    crc_d = crc_q;
    cnt_d = cnt_q;
    if (load) begin
      msg_d = msg_in;
      crc_d = '0;
      cnt_d = '0;
    end else if (step) begin
      crc_d = crc_next;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_q <= '0;
      crc_q <= '0;
      cnt_q <= '0;
    end else begin
      msg_q <= msg_d;
      crc_q <= crc_d;
      cnt_q <= cnt_d;
    end
  end

  assign msg  = msg_q;
  assign last = (cnt_q == CNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/crc3_frame_arbiter.sv
// crc3_frame_arbiter: round-robin scheduler sharing one serial CRC-3 engine
// between NUM_REQ requesters; returns {msg, crc} over a valid/ready handshake.
// Optional feature: define CRC3_ARB_STATS_EN to get an accepted-frame counter
// on frame_cnt; otherwise frame_cnt is tied to zero.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   req         - per-requester request level
//   msg_in      - requester i message on [5*i+4:5*i]
//   grant       - one-hot, one-cycle pulse when a message is captured
//   busy        - high whenever the FSM is not idle
//   code_valid  - codeword available
//   code_ready  - consumer accepts the codeword
//   code_out    - {msg, crc}
//   code_id     - requester that owns code_out
//   frame_cnt   - accepted-codeword counter
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_IDLE  | waiting for any req; arbitrate and load engine
// ST_SHIFT | engine runs 5 data + 3 flush steps
// ST_DONE  | codeword presented, waiting for code_ready
module crc3_frame_arbiter
  import crc3_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*MSG_W-1:0] msg_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     code_valid,
  input  logic                     code_ready,
  output logic [7:0]               code_out,
  output logic [ID_W-1:0]          code_id,
  output logic [15:0]              frame_cnt
);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               code_valid_q, code_valid_d;
  logic [7:0]         code_out_q, code_out_d;
  logic [ID_W-1:0]    code_id_q, code_id_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;

  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [MSG_W-1:0]   win_msg;
  logic               eng_load, eng_step, eng_last;
  logic [MSG_W-1:0]   eng_msg;
  logic [CRC_W-1:0]   eng_crc_next;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    win_msg   = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(last_grant_q) + k) % NUM_REQ;
      cand = ID_W'(idx);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
        win_msg   = msg_in[MSG_W*idx +: MSG_W];
      end
    end
  end

  crc3_shift_engine u_engine (
    .clk      (clk),
    .reset    (reset),
    .load     (eng_load),
    .step     (eng_step),
    .msg_in   (win_msg),
    .msg      (eng_msg),
    .crc_next (eng_crc_next),
    .last     (eng_last)
  );

`ifdef CRC3_ARB_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = '0;
    code_valid_d = code_valid_q;
    code_out_d   = code_out_q;
    code_id_d    = code_id_q;
    last_grant_d = last_grant_q;
    eng_load     = 1'b0;
    eng_step     = 1'b0;
`ifdef CRC3_ARB_STATS_EN
    frame_cnt_d  = frame_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d      = NUM_REQ'(1) << win_idx;
          last_grant_d = win_idx;
          eng_load     = 1'b1;
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        eng_step = 1'b1;
        if (eng_last) begin
          code_out_d   = {eng_msg, eng_crc_next};
          code_id_d    = last_grant_q;   // holds the winner during the frame
          code_valid_d = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        if (code_ready) begin
          code_valid_d = 1'b0;
          state_d      = ST_IDLE;
`ifdef CRC3_ARB_STATS_EN
          frame_cnt_d  = frame_cnt_q + 16'd1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      code_valid_q <= 1'b0;
      code_out_q   <= '0;
      code_id_q    <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
`ifdef CRC3_ARB_STATS_EN
      frame_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      code_valid_q <= code_valid_d;
      code_out_q   <= code_out_d;
      code_id_q    <= code_id_d;
      last_grant_q <= last_grant_d;
`ifdef CRC3_ARB_STATS_EN
      frame_cnt_q  <= frame_cnt_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign busy       = busy_q;
  assign code_valid = code_valid_q;
  assign code_out   = code_out_q;
  assign code_id    = code_id_q;
`ifdef CRC3_ARB_STATS_EN
  assign frame_cnt  = frame_cnt_q;
`else
  assign frame_cnt  = 16'h0000;
`endif

endmodule
